// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine
//   Parametrised snake body controller. Keeps the body as a position history
//   (segment 0 is the head), moves it on an internal tick, grows it on food,
//   detects wall and self collisions and emits one-cycle event pulses for the
//   game FSM.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   state        game state: 00 DIFF_SELECTION, 01 PLAYING, 10 WIN, 11 GAME_OVER
//   up/right/down/left_button  synchronised, active-low direction requests
//   food_valid, food_row, food_col   current food cell
//   grid         grid[r][c] = 1 where a body segment occupies (r,c)
//   head_row, head_col               current head position
//   length       current segment count
//   ate, collision, win              one-cycle event pulses
// -----------------------------------------------------------------------------
module snake_engine #(
  parameter int ROWS        = 10,
  parameter int COLS        = 10,
  parameter int MAX_LENGTH  = 16,
  parameter int INIT_LENGTH = 3,
  parameter int TICK_CYCLES = 4,
  parameter int WRAP_EN     = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        state,
  input  logic                              up_button,
  input  logic                              right_button,
  input  logic                              down_button,
  input  logic                              left_button,
  input  logic                              food_valid,
  input  logic [$clog2(ROWS)-1:0]           food_row,
  input  logic [$clog2(COLS)-1:0]           food_col,
  output logic [ROWS-1:0][COLS-1:0]         grid,
  output logic [$clog2(ROWS)-1:0]           head_row,
  output logic [$clog2(COLS)-1:0]           head_col,
  output logic [$clog2(MAX_LENGTH+1)-1:0]   length,
  output logic                              ate,
  output logic                              collision,
  output logic                              win
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int LW = $clog2(MAX_LENGTH + 1);
  localparam int TW = $clog2(TICK_CYCLES);

  localparam logic [1:0] ST_DIFF = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;

  // Encoding chosen so that the opposite direction is (d + 2) mod 4.
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_e;

  logic [RW-1:0] seg_row [MAX_LENGTH];
  logic [CW-1:0] seg_col [MAX_LENGTH];
  dir_e          dir, pending_dir, ref_dir, press_dir;
  logic          press_valid;
  logic [TW-1:0] tick_cnt;
  logic          dead, active, tick;
  logic [RW-1:0] next_row;
  logic [CW-1:0] next_col;
  logic          wall_hit, body_hit, tail_hit, food_hit, crash, eat;

  assign active   = (state == ST_PLAY) && !dead;
  assign tick     = active && (tick_cnt == TW'(TICK_CYCLES - 1));
  assign head_row = seg_row[0];
  assign head_col = seg_col[0];

  // Button decode. Reversal is judged against the direction that will be
  // committed after this edge, so a press landing on the tick cycle cannot
  // sneak a 180-degree turn past the freshly committed direction.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    ref_dir     = tick ? pending_dir : dir;
    press_valid = 1'b0;
    press_dir   = pending_dir;
    if (!up_button && ref_dir != DIR_DOWN) begin
      press_valid = 1'b1;
      press_dir   = DIR_UP;
    end else if (!right_button && ref_dir != DIR_LEFT) begin
      press_valid = 1'b1;
      press_dir   = DIR_RIGHT;
    end else if (!down_button && ref_dir != DIR_UP) begin
      press_valid = 1'b1;
      press_dir   = DIR_DOWN;
    end else if (!left_button && ref_dir != DIR_RIGHT) begin
      press_valid = 1'b1;
      press_dir   = DIR_LEFT;
    end
  end

  // Next head position; the move uses pending_dir because it is committed on
  // the same tick.
  always_comb begin
    next_row = seg_row[0];
    next_col = seg_col[0];
    wall_hit = 1'b0;
    case (pending_dir)
      DIR_UP:
        if (seg_row[0] == '0) begin
          next_row = RW'(ROWS - 1);
          wall_hit = (WRAP_EN == 0);
        end else next_row = seg_row[0] - RW'(1);
      DIR_DOWN:
        if (seg_row[0] == RW'(ROWS - 1)) begin
          next_row = '0;
          wall_hit = (WRAP_EN == 0);
        end else next_row = seg_row[0] + RW'(1);
      DIR_LEFT:
        if (seg_col[0] == '0) begin
          next_col = CW'(COLS - 1);
          wall_hit = (WRAP_EN == 0);
        end else next_col = seg_col[0] - CW'(1);
      DIR_RIGHT:
        if (seg_col[0] == CW'(COLS - 1)) begin
          next_col = '0;
          wall_hit = (WRAP_EN == 0);
        end else next_col = seg_col[0] + CW'(1);
    endcase
  end

  // Body hit covers segments 0..length-2. The tail only counts when eating,
  // because growth keeps the tail cell occupied.
  always_comb begin
    body_hit = 1'b0;
    tail_hit = 1'b0;
    for (int k = 0; k < MAX_LENGTH; k++) begin
      if (seg_row[k] == next_row && seg_col[k] == next_col) begin
        if (LW'(k) <  length - LW'(1)) body_hit = 1'b1;
        if (LW'(k) == length - LW'(1)) tail_hit = 1'b1;
      end
    end
    food_hit = food_valid && (food_row == next_row) && (food_col == next_col);
    crash    = wall_hit || body_hit || (food_hit && tail_hit);
    eat      = food_hit && !crash;
  end

  always_comb begin
    grid = '0;
    for (int k = 0; k < MAX_LENGTH; k++)
      if (LW'(k) < length) grid[seg_row[k]][seg_col[k]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the body history is small and its reset value defines the initial snake, so it is reset like any other register.
      for (int k = 0; k < MAX_LENGTH; k++) begin
        seg_row[k] <= RW'(ROWS / 2);
        seg_col[k] <= (k < INIT_LENGTH) ? CW'(COLS / 2 - k) : '0;
      end
      length      <= LW'(INIT_LENGTH);
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      tick_cnt    <= '0;
      dead        <= 1'b0;
      ate         <= 1'b0;
      collision   <= 1'b0;
      win         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ate       <= 1'b0;
      collision <= 1'b0;
      win       <= 1'b0;
      if (state == ST_DIFF) begin
        for (int k = 0; k < MAX_LENGTH; k++) begin
          seg_row[k] <= RW'(ROWS / 2);
          seg_col[k] <= (k < INIT_LENGTH) ? CW'(COLS / 2 - k) : '0;
        end
        length      <= LW'(INIT_LENGTH);
        dir         <= DIR_RIGHT;
        pending_dir <= DIR_RIGHT;
        tick_cnt    <= '0;
        dead        <= 1'b0;
      end else if (active) begin
        if (press_valid) pending_dir <= press_dir;
        if (tick) begin
          tick_cnt <= '0;
          dir      <= pending_dir;
          if (crash) begin
            collision <= 1'b1;
            dead      <= 1'b1;
          end else begin
            seg_row[0] <= next_row;
            seg_col[0] <= next_col;
            for (int k = 1; k < MAX_LENGTH; k++) begin
              seg_row[k] <= seg_row[k-1];
              seg_col[k] <= seg_col[k-1];
            end
            if (eat) begin
              ate <= 1'b1;
              if (length < LW'(MAX_LENGTH)) length <= length + LW'(1);
              if (length == LW'(MAX_LENGTH - 1)) win <= 1'b1;
            end
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// -----------------------------------------------------------------------------
// tb_snake_engine
//   Three engines share one stimulus stream: default (wall collisions),
//   WRAP_EN=1 and MAX_LENGTH=4. Expected values are queued as stimulus is
//   driven and popped when the outputs are sampled, 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       up_button, right_button, down_button, left_button;
  logic       food_valid;
  logic [3:0] food_row, food_col;

  logic [9:0][9:0] a_grid, w_grid, m_grid;
  logic [3:0]      a_head_row, a_head_col, w_head_row, w_head_col, m_head_row, m_head_col;
  logic [4:0]      a_length, w_length;
  logic [2:0]      m_length;
  logic            a_ate, a_collision, a_win;
  logic            w_ate, w_collision, w_win;
  logic            m_ate, m_collision, m_win;

  snake_engine #(.WRAP_EN(0)) dut_a (
    .clk(clk), .rst(rst), .state(state),
    .up_button(up_button), .right_button(right_button),
    .down_button(down_button), .left_button(left_button),
    .food_valid(food_valid), .food_row(food_row), .food_col(food_col),
    .grid(a_grid), .head_row(a_head_row), .head_col(a_head_col), .length(a_length),
    .ate(a_ate), .collision(a_collision), .win(a_win)
  );

  snake_engine #(.WRAP_EN(1)) dut_w (
    .clk(clk), .rst(rst), .state(state),
    .up_button(up_button), .right_button(right_button),
    .down_button(down_button), .left_button(left_button),
    .food_valid(food_valid), .food_row(food_row), .food_col(food_col),
    .grid(w_grid), .head_row(w_head_row), .head_col(w_head_col), .length(w_length),
    .ate(w_ate), .collision(w_collision), .win(w_win)
  );

  snake_engine #(.MAX_LENGTH(4)) dut_m (
    .clk(clk), .rst(rst), .state(state),
    .up_button(up_button), .right_button(right_button),
    .down_button(down_button), .left_button(left_button),
    .food_valid(food_valid), .food_row(food_row), .food_col(food_col),
    .grid(m_grid), .head_row(m_head_row), .head_col(m_head_col), .length(m_length),
    .ate(m_ate), .collision(m_collision), .win(m_win)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic exp_n(input string tag, input int v);
    sb.push_back('{tag, 128'(v)});
  endtask

  task automatic exp_g(input string tag, input logic [127:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [127:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h expected=<none>", observed);
      return;
    end
    e = sb.pop_front();
    assert (observed === e.val) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", e.tag, observed, e.val);
    end
  endtask

  // Grid image with up to two non-empty rows (r2 < 0 means unused).
  function automatic logic [127:0] gimg(input int r1, input logic [9:0] v1,
                                        input int r2, input logic [9:0] v2);
    logic [9:0][9:0] x;
    x = '0;
    x[r1] = v1;
    if (r2 >= 0) x[r2] = v2;
    return 128'(x);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_buttons();
    up_button = 1'b1; right_button = 1'b1; down_button = 1'b1; left_button = 1'b1;
  endtask

  // One press right after a tick, then wait out the rest of the move period.
  task automatic move(input int d);
    case (d)
      0: up_button    = 1'b0;
      1: right_button = 1'b0;
      2: down_button  = 1'b0;
      default: left_button = 1'b0;
    endcase
    step(1);
    release_buttons();
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; state = 2'b00; release_buttons();
    food_valid = 1'b0; food_row = '0; food_col = '0;
    step(2);
    rst = 1'b1;
    exp_n("rst_head_row", 5); exp_n("rst_head_col", 5); exp_n("rst_length", 3);
    exp_g("rst_grid", gimg(5, 10'h038, -1, '0)); exp_n("rst_pulses", 0);
    exp_n("rst_m_length", 3);
    step(1);
    check(128'(a_head_row)); check(128'(a_head_col)); check(128'(a_length));
    check(128'(a_grid)); check(128'({a_ate, a_collision, a_win}));
    check(128'(m_length));

    // Enter PLAYING with food just ahead of the head.
    state = 2'b01; food_valid = 1'b1; food_row = 4'd5; food_col = 4'd6;
    exp_n("pre_tick_col", 5); exp_n("pre_tick_pulses", 0);
    exp_n("eat_head_col", 6); exp_n("eat_length", 4);
    exp_g("eat_grid", gimg(5, 10'h078, -1, '0)); exp_n("eat_pulses", 4);
    exp_n("win_m_length", 4); exp_n("win_m_pulses", 5); exp_n("eat_w_pulses", 4);
    step(3);
    check(128'(a_head_col)); check(128'({a_ate, a_collision, a_win}));
    step(1);
    check(128'(a_head_col)); check(128'(a_length)); check(128'(a_grid));
    check(128'({a_ate, a_collision, a_win}));
    check(128'(m_length)); check(128'({m_ate, m_collision, m_win}));
    check(128'({w_ate, w_collision, w_win}));

    food_valid = 1'b0;
    exp_n("move2_head_col", 7); exp_g("move2_grid", gimg(5, 10'h0F0, -1, '0));
    exp_n("move2_pulses", 0); exp_n("move2_m_pulses", 0);
    step(4);
    check(128'(a_head_col)); check(128'(a_grid));
    check(128'({a_ate, a_collision, a_win})); check(128'({m_ate, m_collision, m_win}));

    // Mid-period switch to WIN with a button held; counter must resume later.
    step(2);
    state = 2'b10; up_button = 1'b0;
    exp_n("win_frozen_col", 7); exp_n("win_frozen_m_len", 4); exp_n("win_frozen_pulses", 0);
    step(5);
    check(128'(a_head_col)); check(128'(m_length)); check(128'({m_ate, m_collision, m_win}));
    release_buttons(); state = 2'b01;
    exp_n("resume_no_move_col", 7); exp_n("resume_move_col", 8); exp_n("resume_move_row", 5);
    step(1);
    check(128'(a_head_col));
    step(1);
    check(128'(a_head_col)); check(128'(a_head_row));

    // Reverse press ignored; down+left together selects down.
    left_button = 1'b0;
    step(1);
    down_button = 1'b0;
    step(1);
    release_buttons();
    exp_n("turn_head_row", 6); exp_n("turn_head_col", 8);
    exp_g("turn_grid", gimg(5, 10'h1C0, 6, 10'h100));
    step(2);
    check(128'(a_head_row)); check(128'(a_head_col)); check(128'(a_grid));

    move(1);
    exp_n("edge_head_col", 9); exp_n("edge_w_head_col", 9);
    check(128'(a_head_col)); check(128'(w_head_col));

    // Right edge: wall collision without wrap, wrap to column 0 with it.
    exp_n("wall_pulses", 2); exp_n("wall_head_col", 9); exp_n("wall_m_pulses", 2);
    exp_n("wrap_head_col", 0); exp_n("wrap_pulses", 0);
    step(4);
    check(128'({a_ate, a_collision, a_win})); check(128'(a_head_col));
    check(128'({m_ate, m_collision, m_win}));
    check(128'(w_head_col)); check(128'({w_ate, w_collision, w_win}));
    exp_n("wall_pulse_end", 0);
    step(1);
    check(128'({a_ate, a_collision, a_win}));
    exp_n("dead_head_col", 9); exp_n("wrap2_head_col", 2); exp_n("wrap2_head_row", 6);
    step(7);
    check(128'(a_head_col)); check(128'(w_head_col)); check(128'(w_head_row));

    // Loop back into the vacated tail cell: legal.
    move(2);
    move(3);
    exp_n("tail_head_row", 6); exp_n("tail_head_col", 1); exp_n("tail_pulses", 0);
    exp_g("tail_grid", gimg(6, 10'h006, 7, 10'h006));
    move(0);
    check(128'(w_head_row)); check(128'(w_head_col));
    check(128'({w_ate, w_collision, w_win})); check(128'(w_grid));

    // Food on the tail cell: tail stays, so collision wins and nothing is eaten.
    food_valid = 1'b1; food_row = 4'd6; food_col = 4'd2;
    exp_n("tailfood_pulses", 2); exp_n("tailfood_head_col", 1); exp_n("tailfood_length", 4);
    move(1);
    check(128'({w_ate, w_collision, w_win})); check(128'(w_head_col)); check(128'(w_length));

    // DIFF_SELECTION restores the initial snake and clears the dead flag.
    food_valid = 1'b0; state = 2'b00;
    exp_n("diff_head_row", 5); exp_n("diff_head_col", 5); exp_n("diff_length", 3);
    exp_n("diff_m_length", 3); exp_n("diff_w_pulses", 0);
    step(1);
    check(128'(a_head_row)); check(128'(a_head_col)); check(128'(a_length));
    check(128'(m_length)); check(128'({w_ate, w_collision, w_win}));
    state = 2'b01;
    exp_n("replay_head_col", 6);
    step(4);
    check(128'(a_head_col));

    // Asynchronous reset mid-period.
    step(2);
    rst = 1'b0;
    exp_n("async_rst_head_col", 5); exp_n("async_rst_length", 3);
    #1;
    check(128'(a_head_col)); check(128'(a_length));
    rst = 1'b1;

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor to the fixed-length snake controller.
- Keeps the snake body as a position history of up to MAX_LENGTH segments and moves it on an internal tick.
- Grows the snake on food, detects wall and self collisions, and reports win and collision events to the game FSM.
- Sits between the button synchronisers and the grid renderer; the FSM drives the `state` input and consumes the event pulses.

Parameters:
ROWS, 10, grid rows (>=4)
COLS, 10, grid columns (>=4)
MAX_LENGTH, 16, maximum body segments (>=INIT_LENGTH+1)
INIT_LENGTH, 3, body length after reset/restart (2..COLS/2)
TICK_CYCLES, 4, clock cycles per move (>=2)
WRAP_EN, 0, 1 = wrap at edges; 0 = edge is a wall collision

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
state  in  2  game state: 00 DIFF_SELECTION, 01 PLAYING, 10 WIN, 11 GAME_OVER
up_button  in  1  active-low, synchronised
right_button  in  1  active-low, synchronised
down_button  in  1  active-low, synchronised
left_button  in  1  active-low, synchronised
food_valid  in  1  food present at food_row/food_col
food_row  in  $clog2(ROWS)  food row
food_col  in  $clog2(COLS)  food column
grid  out  ROWS x COLS  grid[r][c]=1 where a body segment occupies (r,c)
head_row  out  $clog2(ROWS)  current head row
head_col  out  $clog2(COLS)  current head column
length  out  $clog2(MAX_LENGTH+1)  current segment count
ate  out  1  one-cycle pulse on the move that consumed food
collision  out  1  one-cycle pulse on the tick that detected a collision
win  out  1  one-cycle pulse when length reaches MAX_LENGTH

Behaviour:
- Reset (rst=0, async), and every cycle state==DIFF_SELECTION:
  - head=(ROWS/2, COLS/2); segment k at (ROWS/2, COLS/2-k) for k<INIT_LENGTH.
  - length=INIT_LENGTH; dir=RIGHT; pending_dir=RIGHT; tick counter=0.
  - ate/collision/win=0; internal dead flag cleared.
- Direction:
  - Active only in PLAYING; buttons are ignored in all other states.
  - A pressed button (level 0) loads pending_dir the same cycle.
  - Simultaneous presses: priority up > right > down > left.
  - A press opposite to the committed dir is ignored.
  - pending_dir is committed to dir at the tick only.
- Tick:
  - Counter runs only in PLAYING with dead=0.
  - Counts 0..TICK_CYCLES-1; tick asserts when the count is TICK_CYCLES-1, then the counter returns to 0.
  - First move occurs TICK_CYCLES cycles after entering PLAYING.
- Move, on tick:
  - Next head = head + dir.
  - WRAP_EN=1: row/col wrap modulo ROWS/COLS.
  - WRAP_EN=0: leaving the grid is a collision.
- Self collision: next head equals any segment 0..length-2. The tail cell is vacated, so moving into it is legal, except when eating.
- Eat: food_valid and next head == food position.
  - Segments shift and length increments, saturating at MAX_LENGTH.
  - ate pulses.
  - If the new length == MAX_LENGTH, win pulses the same cycle.
- Collision: body does not move; collision pulses; dead=1 freezes the engine until reset or DIFF_SELECTION.
- Collision and food on the same target cell: collision wins, no ate.
- WIN and GAME_OVER states: body, length and counter frozen; no pulses.
- Leaving PLAYING and returning to it without passing through DIFF_SELECTION resumes the held counter.
- Outputs:
  - All outputs except grid are registered; event pulses assert the cycle after the tick edge.
  - grid is a combinational decode of the segment registers and updates with the body.
- Reset mid-move: restores the initial snake regardless of the counter value.

Test Plan:
- Defaults, rst=0 then 1, state=00 → head (5,5), length=3, grid[5] bits 3,4,5 set, all pulses 0.
- state=01, no buttons → after 4 cycles head (5,6), grid[5] bits 4,5,6; after 8 cycles head (5,7).
- PLAYING moving right: press left, then down+left together → left ignored; down wins; next tick head (6,col) unchanged col.
- food (5,6) valid at first tick → ate pulse, length=4, grid[5] bits 3..6.
- WRAP_EN=0, run right until head (5,9), next tick → collision pulse, head stays (5,9), no further moves. Repeat with WRAP_EN=1 → head (5,0), no collision.
- MAX_LENGTH=4, eat once → ate and win pulse same cycle, length=4. Then state=10 → frozen, buttons ignored. state=00 → length=3, head (5,5).
